sequenciador_senha: RTL and testbench

- Sequential password checker for the lock.
- Latches an N-digit entered code and an N-digit stored code, then compares them one byte per cycle through a single shared 8-bit magnitude comparator.
- Reports a correct or incorrect result, counts consecutive failures, and enforces a timed lockout after too many failures.
- Sits between the keypad/entry logic and the lock actuator control in the Polilock datapath.

---
 rtl/sequenciador_senha_pkg.sv | 24 ++
 rtl/sequenciador_senha_comparador.sv | 14 +
 rtl/sequenciador_senha.sv | 142 ++++++++++++++
 tb/tb_sequenciador_senha.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_senha_pkg.sv
// Shared Polilock definitions: password-checker state encoding and default sizing.
package polilock_pkg;

  localparam int N_DIGITOS_PADRAO       = 4;
  localparam int MAX_TENTATIVAS_PADRAO  = 3;
  localparam int BLOQUEIO_CICLOS_PADRAO = 1000;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    COMPARA  = 3'd1,
    ACERTO   = 3'd2,
    ERRO     = 3'd3,
    BLOQUEIO = 3'd4
  } t_estado;

  // Observation bundle for checkers: FSM state, digit index and the unused comparator flags.
  typedef struct packed {
    t_estado    estado;
    logic [3:0] indice;
    logic       alb;
    logic       agb;
  } t_dbg;

endpackage

// File: rtl/sequenciador_senha_comparador.sv
// 8-bit magnitude comparator shared by all digit positions of the password checker.
module comparador_8b (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic       o_aeb,
  output logic       o_alb,
  output logic       o_agb
);

  assign o_aeb = (i_a == i_b);
  assign o_alb = (i_a <  i_b);
  assign o_agb = (i_a >  i_b);

endmodule

// File: rtl/sequenciador_senha.sv
// Sequential password checker: latches both codes, compares one digit per cycle,
// counts consecutive failures and holds a timed lockout after too many.
module sequenciador_senha
  import polilock_pkg::*;
#(
  parameter  int N_DIGITOS       = N_DIGITOS_PADRAO,
  parameter  int MAX_TENTATIVAS  = MAX_TENTATIVAS_PADRAO,
  parameter  int BLOQUEIO_CICLOS = BLOQUEIO_CICLOS_PADRAO,
  localparam int W_TENT          = $clog2(MAX_TENTATIVAS + 1),
  localparam int W_TIMER         = $clog2(BLOQUEIO_CICLOS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [8*N_DIGITOS-1:0] senha_entrada,
  input  logic [8*N_DIGITOS-1:0] senha_armazenada,
  output logic                   pronto,
  output logic                   fim,
  output logic                   correta,
  output logic                   incorreta,
  output logic                   bloqueado,
  output logic [W_TENT-1:0]      tentativas,
  output logic [3:0]             indice_erro,
  output t_dbg                   dbg
);

  localparam logic [3:0]         ULTIMO     = 4'(N_DIGITOS - 1);
  localparam logic [W_TENT-1:0]  TENT_LIM   = W_TENT'(MAX_TENTATIVAS - 1);
  localparam logic [W_TENT-1:0]  TENT_MAX   = W_TENT'(MAX_TENTATIVAS);
  localparam logic [W_TIMER-1:0] TIMER_INI  = W_TIMER'(BLOQUEIO_CICLOS - 1);

  t_estado                r_estado;
  t_estado                w_prox_estado;
  logic [3:0]             r_indice;
  logic [3:0]             r_indice_erro;
  logic [W_TENT-1:0]      r_tent;
  logic [W_TIMER-1:0]     r_timer;
  logic [8*N_DIGITOS-1:0] r_senha_a;
  logic [8*N_DIGITOS-1:0] r_senha_b;
  logic [7:0]             w_dig_a;
  logic [7:0]             w_dig_b;
  logic                   w_aeb;
  logic                   w_alb;
  logic                   w_agb;

  // Digit mux built from constant selects so the index never addresses past the last digit.
  always_comb begin
    w_dig_a = '0;
    w_dig_b = '0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (r_indice == 4'(i)) begin
        w_dig_a = r_senha_a[8*i +: 8];
        w_dig_b = r_senha_b[8*i +: 8];
      end
    end
  end

  comparador_8b u_comparador (
    .i_a   (w_dig_a),
    .i_b   (w_dig_b),
    .o_aeb (w_aeb),
    .o_alb (w_alb),
    .o_agb (w_agb)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= OCIOSO;
    else        r_estado <= w_prox_estado;
  end

  // Handshake: a start is accepted on any rising edge where pronto and iniciar are both high;
  // iniciar seen while pronto is low is dropped, never queued.
  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO:   if (iniciar) w_prox_estado = COMPARA;
      COMPARA: begin
        if (!w_aeb)                  w_prox_estado = ERRO;
        else if (r_indice == ULTIMO) w_prox_estado = ACERTO;
      end
      ACERTO:   w_prox_estado = OCIOSO;
      ERRO:     w_prox_estado = (r_tent == TENT_LIM) ? BLOQUEIO : OCIOSO;
      BLOQUEIO: if (r_timer == '0) w_prox_estado = OCIOSO;
      default:  w_prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_indice      <= '0;
      r_indice_erro <= '0;
      r_tent        <= '0;
      r_timer       <= '0;
      r_senha_a     <= '0;
      r_senha_b     <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            r_senha_a <= senha_entrada;
            r_senha_b <= senha_armazenada;
            r_indice  <= '0;
          end
        end
        COMPARA: begin
          if (!w_aeb)                  r_indice_erro <= r_indice;
          else if (r_indice != ULTIMO) r_indice      <= r_indice + 4'd1;
        end
        ACERTO: r_tent <= '0;
        ERRO: begin
          if (r_tent == TENT_LIM) begin
            r_tent  <= TENT_MAX;
            r_timer <= TIMER_INI;
          end else begin
            r_tent <= r_tent + 1'b1;
          end
        end
        BLOQUEIO: begin
          if (r_timer == '0) r_tent  <= '0;
          else               r_timer <= r_timer - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pronto      = (r_estado == OCIOSO);
    fim         = (r_estado == ACERTO) || (r_estado == ERRO);
    correta     = (r_estado == ACERTO);
    incorreta   = (r_estado == ERRO);
    bloqueado   = (r_estado == BLOQUEIO);
    tentativas  = r_tent;
    indice_erro = r_indice_erro;
    dbg         = '0;
    dbg.estado  = r_estado;
    dbg.indice  = r_indice;
    dbg.alb     = w_alb;
    dbg.agb     = w_agb;
  end

endmodule

// File: tb/tb_sequenciador_senha.sv
// Bench for sequenciador_senha: directed latency/lockout/reset cases plus random traffic,
// all checked every cycle against a per-start schedule of expected outputs.
module tb_sequenciador_senha;
  import polilock_pkg::*;

  localparam int N   = 4;
  localparam int MAX = 3;
  localparam int B   = 8;
  localparam int W_T = $clog2(MAX + 1);
  localparam int EW  = 5 + W_T + 4;

  logic           clock;
  logic           reset;
  logic           iniciar;
  logic [8*N-1:0] senha_entrada;
  logic [8*N-1:0] senha_armazenada;
  logic           pronto, fim, correta, incorreta, bloqueado;
  logic [W_T-1:0] tentativas;
  logic [3:0]     indice_erro;
  t_dbg           dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];
  int            m_tent   = 0;
  int            m_ierr   = 0;
  bit            cur_idle = 1;

  sequenciador_senha #(
    .N_DIGITOS       (N),
    .MAX_TENTATIVAS  (MAX),
    .BLOQUEIO_CICLOS (B)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .senha_entrada    (senha_entrada),
    .senha_armazenada (senha_armazenada),
    .pronto           (pronto),
    .fim              (fim),
    .correta          (correta),
    .incorreta        (incorreta),
    .bloqueado        (bloqueado),
    .tentativas       (tentativas),
    .indice_erro      (indice_erro),
    .dbg              (dbg)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic p, input logic f, input logic c,
                                       input logic i, input logic b, input int t, input int e);
    return {p, f, c, i, b, W_T'(t), 4'(e)};
  endfunction

  function automatic logic [EW-1:0] outs();
    return {pronto, fim, correta, incorreta, bloqueado, tentativas, indice_erro};
  endfunction

  // Behavioural model: an accepted start expands into the full timeline of expected outputs.
  task automatic model_start(input logic [8*N-1:0] a, input logic [8*N-1:0] b);
    int k;
    k = N;
    for (int i = N - 1; i >= 0; i--)
      if (a[8*i +: 8] != b[8*i +: 8]) k = i;
    if (k == N) begin
      repeat (N) exp_q.push_back(mk(0, 0, 0, 0, 0, m_tent, m_ierr));
      exp_q.push_back(mk(0, 1, 1, 0, 0, m_tent, m_ierr));
      m_tent = 0;
    end else begin
      repeat (k + 1) exp_q.push_back(mk(0, 0, 0, 0, 0, m_tent, m_ierr));
      exp_q.push_back(mk(0, 1, 0, 1, 0, m_tent, k));
      m_ierr = k;
      if (m_tent + 1 == MAX) begin
        repeat (B) exp_q.push_back(mk(0, 0, 0, 0, 1, MAX, k));
        m_tent = 0;
      end else begin
        m_tent = m_tent + 1;
      end
    end
  endtask

  // Scoreboard / compare process
  always @(posedge clock) begin
    logic [EW-1:0] e;
    if (!reset) begin
      exp_q.delete();
      m_tent   = 0;
      m_ierr   = 0;
      cur_idle = 1;
    end else begin
      if (cur_idle && iniciar) model_start(senha_entrada, senha_armazenada);
      #1;
      if (reset) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          cur_idle = 0;
        end else begin
          e = mk(1, 0, 0, 0, 0, m_tent, m_ierr);
          cur_idle = 1;
        end
        check("ciclo", 32'(outs()), 32'(e));
      end
    end
  end

  // Driver tasks
  task automatic wait_pronto();
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (pronto) return;
    end
    check("timeout_pronto", 32'(pronto), 32'd1);
  endtask

  task automatic run(input logic [8*N-1:0] a, input logic [8*N-1:0] b,
                     input bit mudar, input logic [8*N-1:0] novo, output int lat);
    wait_pronto();
    @(negedge clock);
    senha_entrada    = a;
    senha_armazenada = b;
    iniciar          = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iniciar = 1'b0;
    if (mudar) senha_entrada = novo;
    lat = 99;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clock); #1;
      if (fim) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic lockout_watch(output int cnt);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (!bloqueado) break;
      cnt++;
      check("fim_no_bloqueio", 32'(fim), 32'd0);
      iniciar = (cnt < 4);
    end
    iniciar = 1'b0;
  endtask

  localparam logic [31:0] OK   = 32'h01020304;
  localparam logic [31:0] ERR2 = 32'h01FF0304;
  localparam logic [31:0] ERR0 = 32'h01020300;
  localparam logic [31:0] ERR3 = 32'hAA020304;
  localparam logic [EW-1:0] RST_OUT = {1'b1, 4'b0000, {W_T{1'b0}}, 4'd0};

  initial begin
    int lat;
    int cnt;
    logic [8*N-1:0] tmp;
    int d;

    reset            = 1'b0;
    iniciar          = 1'b0;
    senha_entrada    = '0;
    senha_armazenada = '0;
    #3;
    check("reset_saidas", 32'(outs()), 32'(RST_OUT));
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run(OK, OK, 0, '0, lat);
    check("acerto_latencia", lat, 5);
    check("acerto_correta", 32'(correta), 32'd1);
    check("acerto_tent", 32'(tentativas), 32'd0);
    @(posedge clock); #1;
    check("acerto_pronto", 32'(pronto), 32'd1);

    run(ERR2, OK, 0, '0, lat);
    check("erro2_latencia", lat, 4);
    check("erro2_incorreta", 32'(incorreta), 32'd1);
    check("erro2_indice", 32'(indice_erro), 32'd2);
    @(posedge clock); #1;
    check("erro2_tent", 32'(tentativas), 32'd1);

    run(ERR0, OK, 0, '0, lat);
    check("erro0_latencia", lat, 2);
    check("erro0_indice", 32'(indice_erro), 32'd0);
    @(posedge clock); #1;
    check("erro0_tent", 32'(tentativas), 32'd2);

    run(OK, OK, 0, '0, lat);
    check("recupera_latencia", lat, 5);
    @(posedge clock); #1;
    check("recupera_tent", 32'(tentativas), 32'd0);
    check("recupera_sem_bloqueio", 32'(bloqueado), 32'd0);

    for (int j = 0; j < 3; j++) begin
      run(ERR2, OK, 0, '0, lat);
      check("bloq_latencia", lat, 4);
    end
    lockout_watch(cnt);
    check("bloq_duracao", cnt, B);
    check("bloq_fim_pronto", 32'(pronto), 32'd1);
    check("bloq_fim_tent", 32'(tentativas), 32'd0);

    run(OK, OK, 1, 32'hDEADBEEF, lat);
    check("latch_latencia", lat, 5);
    check("latch_correta", 32'(correta), 32'd1);

    run(ERR3, OK, 0, '0, lat);
    check("erro3_indice", 32'(indice_erro), 32'd3);
    wait_pronto();
    @(negedge clock);
    senha_entrada    = OK;
    senha_armazenada = OK;
    iniciar          = 1'b1;
    @(posedge clock);
    @(negedge clock);
    iniciar = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1 check("reset_compara", 32'(outs()), 32'(RST_OUT));
    repeat (3) begin
      @(posedge clock); #1;
      check("reset_sem_fim", 32'(fim), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    run(OK, OK, 0, '0, lat);
    check("pos_reset1_latencia", lat, 5);
    check("pos_reset1_correta", 32'(correta), 32'd1);

    for (int j = 0; j < 3; j++) run(ERR0, OK, 0, '0, lat);
    repeat (3) @(posedge clock);
    #1 check("bloq_ativo", 32'(bloqueado), 32'd1);
    #1 reset = 1'b0;
    #1 check("reset_bloqueio", 32'(outs()), 32'(RST_OUT));
    @(posedge clock); #1;
    check("reset_bloq_sem_fim", 32'(fim), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run(OK, OK, 0, '0, lat);
    check("pos_reset2_latencia", lat, 5);
    check("pos_reset2_correta", 32'(correta), 32'd1);

    // Random traffic, including iniciar held high and during lockout
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      iniciar = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) senha_armazenada = 32'($urandom);
      case ($urandom_range(0, 3))
        0: senha_entrada = senha_armazenada;
        1: begin
          tmp = senha_armazenada;
          d   = $urandom_range(0, N - 1);
          tmp[8*d +: 8] = tmp[8*d +: 8] ^ 8'($urandom_range(1, 255));
          senha_entrada = tmp;
        end
        2: senha_entrada = 32'($urandom);
        default: ;
      endcase
    end
    @(negedge clock);
    iniciar = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
